mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer for the unified instruction/data memory of the multicycle RV32I core. It sits between the memory and two requesters: the core datapath (instruction fetch, loads and stores) and a program-loader/debug port. It serialises their accesses one per cycle, returns registered read data, and lets the loader lock the memory for bulk download while the core is held off.

## Interface
Parameters:
- `AW`, 32, address width (byte address, passed through unchanged to memory)
- `DW`, 32, data width
- `MAX_WAIT`, 8, consecutive core grants tolerated while the loader waits (anti-starvation; range 1..255)

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (low = reset)
- `c_req`  in  1  core access request; held with address/data until `c_gnt`
- `c_we`  in  1  core write enable
- `c_addr`  in  AW  core address
- `c_wdata`  in  DW  core write data
- `c_gnt`  out  1  core access performed this cycle; core FSM advances on it
- `c_rdata`  out  DW  core read data, registered
- `c_rvalid`  out  1  one-cycle pulse, `c_rdata` valid
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_gnt`, `l_rdata`, `l_rvalid`: loader port, same semantics
- `l_lock`  in  1  loader requests exclusive ownership
- `mem_we`  out  1  to memory write enable
- `mem_a`  out  AW  to memory address
- `mem_wd`  out  DW  to memory write data
- `mem_rd`  in  DW  from memory, combinational read

## Operation
- States: IDLE, GC (core granted), GL (loader granted), LOCK.
- In GC/GL/LOCK the selected port's `req/we/addr/wdata` drive `mem_*`; its `gnt` = 1 that cycle; `mem_we` = selected `we` AND `req`. In IDLE `mem_we` = 0, `mem_a`/`mem_wd` = 0.
- Next-state decision in every state, from current `c_req`, `l_req`, `l_lock`, excluding a request granted this cycle unless it is re-asserted with a new transaction:
  - `l_lock` && `l_req` → LOCK; else starvation trigger && `l_req` → GL; else `c_req` → GC; else `l_req` → GL; else IDLE.
- LOCK: loader granted every cycle `l_req` is high; `c_gnt` = 0 regardless of `c_req`; exit to the normal decision when `l_lock` falls (exit takes effect next cycle).
- Reads: on any granted cycle with `we` = 0, `mem_rd` is registered into that port's `rdata`; `rvalid` pulses the next cycle. `rdata` holds its value otherwise. Writes never pulse `rvalid`.
- Granted request with `req` dropped in the same cycle cannot happen: `gnt` is only asserted while `req` = 1 (state falls to decision logic with no access).

## Timing
- Reset (async assert, sync release): state IDLE, all `gnt` = 0, `rvalid` = 0, `rdata` = 0, `mem_we` = 0, `mem_a` = 0, `mem_wd` = 0, wait counter 0. Reset mid-access aborts it; no write is issued in the reset cycle.
- Latency from IDLE: request at cycle N → `gnt` at N+1 → `rvalid` at N+2.
- Back-to-back: from a grant state, a pending request is granted the following cycle, no bubble; sustained throughput 1 access/cycle.
- Simultaneous `c_req` and `l_req` with no lock/starvation: core wins.
- Write in cycle N visible to a read granted in cycle N+1 or later.

## Configuration
- `MEM_ARB_STARVE_EN` defined: counter increments each cycle the core is granted while `l_req` is pending and not granted; saturates at `MAX_WAIT`; at `MAX_WAIT` the starvation trigger is true; cleared to 0 on any `l_gnt`.
- Undefined: no counter, trigger constant 0; pure fixed core priority (loader may starve unless it uses `l_lock`).

## Test plan
- Reset: drive requests during `rst` = 0 → all outputs 0; release, `c_req` read of 0x0 → `c_gnt` next cycle, `c_rvalid` the cycle after with memory word at 0x0.
- Loader write 0x00000013 to 0x40 then core read 0x40 → `c_rdata` = 0x00000013, one access per cycle, no bubble.
- Simultaneous `c_req`/`l_req` from IDLE → `c_gnt` first, `l_gnt` next cycle when core drops `c_req`.
- With `MEM_ARB_STARVE_EN`, `MAX_WAIT` = 8, core requesting continuously and loader pending → exactly 8 core grants, then one `l_gnt`, then core resumes; without the macro `l_gnt` never asserts.
- `l_lock` = 1 with 16 loader writes while `c_req` = 1 → `c_gnt` stays 0 throughout; first `c_gnt` one cycle after `l_lock` falls.
- Assert `rst` low during a loader write grant → `mem_we` drops immediately, target word unchanged if reset precedes the clock edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbiter/sequencer between the unified RV32I memory and two
// requesters (core datapath and program-loader/debug port). One access per
// cycle, registered read data per port, and a loader lock for bulk download.
// Optional feature: define MEM_ARB_STARVE_EN to add the loader anti-starvation
// counter. Without it the core always has priority, unless the loader locks.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic [DW-1:0] c_rdata,
  output logic          c_rvalid,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic [DW-1:0] l_rdata,
  output logic          l_rvalid,
  input  logic          l_lock,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  // The wait counter is 8 bits wide, so the limit must fit.
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_arbiter: MAX_WAIT must be in 1..255");
  end

  // IDLE: no owner; GC: core owns this cycle; GL: loader owns this cycle;
  // LOCK: loader owns the memory until it drops l_lock.
  typedef enum logic [1:0] {IDLE, GC, GL, LOCK} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] l_rdata_q, l_rdata_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic          c_sel, l_sel;
  logic          starve;

  // Route the owning port to the memory; a grant needs a live request.
  always_comb begin
    c_sel  = (state_q == GC);
    l_sel  = (state_q == GL) || (state_q == LOCK);
    c_gnt  = c_sel & c_req;
    l_gnt  = l_sel & l_req;
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (c_sel) begin
      mem_we = c_we & c_req;
      mem_a  = c_addr;
      mem_wd = c_wdata;
    end else if (l_sel) begin
      mem_we = l_we & l_req;
      mem_a  = l_addr;
      mem_wd = l_wdata;
    end
  end

`ifdef MEM_ARB_STARVE_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Count core grants that bypass a waiting loader; any loader grant clears it.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (l_gnt) begin
      wait_cnt_d = '0;
    end else if (c_gnt && l_req && (wait_cnt_q != WAIT_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Looking at the updated count lets the loader in right after the
  // MAX_WAIT-th bypassing core grant rather than one grant later.
  assign starve = (wait_cnt_d == WAIT_LIMIT);
`else
  assign starve = 1'b0;
`endif

  // Choose next cycle's owner from the live requests; a lock holds until dropped.
  always_comb begin
    state_d = IDLE;
    if ((state_q == LOCK) && l_lock) begin
      state_d = LOCK;
    end else if (l_lock && l_req) begin
      state_d = LOCK;
    end else if (starve && l_req) begin
      state_d = GL;
    end else if (c_req) begin
      state_d = GC;
    end else if (l_req) begin
      state_d = GL;
    end
  end

  // Capture read data for whichever port performs a read this cycle.
  always_comb begin
    c_rdata_d  = c_rdata_q;
    l_rdata_d  = l_rdata_q;
    c_rvalid_d = 1'b0;
    l_rvalid_d = 1'b0;
    if (c_gnt && !c_we) begin
      c_rdata_d  = mem_rd;
      c_rvalid_d = 1'b1;
    end
    if (l_gnt && !l_we) begin
      l_rdata_d  = mem_rd;
      l_rvalid_d = 1'b1;
    end
  end

  // State and read-return registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_rdata_q  <= c_rdata_d;
      l_rdata_q  <= l_rdata_d;
      c_rvalid_q <= c_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
    end
  end

  assign c_rdata  = c_rdata_q;
  assign l_rdata  = l_rdata_q;
  assign c_rvalid = c_rvalid_q;
  assign l_rvalid = l_rvalid_q;

endmodule
